// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit out per bit_en strobe.
// A one-word hold register lets the next word load on the same edge that consumes the last bit.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             bit_en,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;

    // Advance the shifter one position toward the output end, zero-filling behind.
    function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] s);
        if (MSB_FIRST)
            return {s[WIDTH-2:0], 1'b0};
        else
            return {1'b0, s[WIDTH-1:1]};
    endfunction

    function automatic logic out_end_bit(input logic [WIDTH-1:0] s);
        if (MSB_FIRST)
            return s[WIDTH-1];
        else
            return s[0];
    endfunction

    assign accept = din_valid && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    if (cnt_q != LAST_CNT) begin
                        shift_d = shift_toward_out(shift_q);
                        cnt_d   = cnt_q + 1'b1;
                    end else if (hold_full_q) begin
                        // Chain straight into the held word: no idle cycle between frames.
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        cnt_d       = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept only into an empty hold, so it never collides with a drain above.
        if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
        end
    end

    // All outputs decode registered state only.
    assign din_ready   = !hold_full_q;
    assign bit_valid   = (state_q == SHIFT);
    assign bit_out     = bit_valid && out_end_bit(shift_q);
    assign frame_start = bit_valid && (cnt_q == '0);
    assign frame_end   = bit_valid && (cnt_q == LAST_CNT);

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances driven in parallel and compared each
// cycle against a word/bit-index reference model, plus directed frames with known bit strings.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clk_run = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         bit_en = 1'b0;

    logic rdy_m, bo_m, bv_m, fs_m, fe_m;
    logic rdy_l, bo_l, bv_l, fs_l, fe_l;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
        .bit_en(bit_en), .bit_out(bo_m), .bit_valid(bv_m), .frame_start(fs_m), .frame_end(fe_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
        .bit_en(bit_en), .bit_out(bo_l), .bit_valid(bv_l), .frame_start(fs_l), .frame_end(fe_l)
    );

    always #5 if (clk_run) clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the word in the hold slot, and the word being sent plus bit index.
    logic [W-1:0] pend[$];
    logic [W-1:0] cur;
    int           idx;
    bit           active;

    function automatic void model_reset();
        pend.delete();
        cur    = '0;
        idx    = 0;
        active = 1'b0;
    endfunction

    function automatic bit model_step(input bit v, input logic [W-1:0] d, input bit e);
        bit had = (pend.size() != 0);
        if (!active) begin
            if (had) begin
                cur = pend.pop_front(); idx = 0; active = 1'b1;
            end
        end else if (e) begin
            if (idx < W - 1) idx++;
            else if (had) begin
                cur = pend.pop_front(); idx = 0;
            end else active = 1'b0;
        end
        if (v && !had) pend.push_back(d);
        return v && !had;
    endfunction

    task automatic check_outputs();
        logic exp_m, exp_l;
        exp_m = active ? cur[W-1-idx] : 1'b0;
        exp_l = active ? cur[idx]     : 1'b0;
        chk("din_ready_msb",   rdy_m, (pend.size() == 0));
        chk("din_ready_lsb",   rdy_l, (pend.size() == 0));
        chk("bit_valid_msb",   bv_m,  active);
        chk("bit_valid_lsb",   bv_l,  active);
        chk("bit_out_msb",     bo_m,  exp_m);
        chk("bit_out_lsb",     bo_l,  exp_l);
        chk("frame_start_msb", fs_m,  active && idx == 0);
        chk("frame_start_lsb", fs_l,  active && idx == 0);
        chk("frame_end_msb",   fe_m,  active && idx == W - 1);
        chk("frame_end_lsb",   fe_l,  active && idx == W - 1);
    endtask

    logic [31:0] got_m, got_l;
    int nbits, nvalid, nfs, nfe;

    task automatic clear_stats();
        got_m = '0; got_l = '0; nbits = 0; nvalid = 0; nfs = 0; nfe = 0;
    endtask

    // Called at a negedge: drive inputs, log consumed bits, advance model, check at next negedge.
    task automatic step(input bit v, input logic [W-1:0] d, input bit e, output bit acc);
        din_valid = v; din = d; bit_en = e;
        if (bv_m && e) begin
            got_m = {got_m[30:0], bo_m};
            got_l = {got_l[30:0], bo_l};
            nbits++;
        end
        if (bv_m) nvalid++;
        if (fs_m) nfs++;
        if (fe_m) nfe++;
        acc = model_step(v, d, e);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1 model_reset();
        chk("rst_din_ready", rdy_m, 1'b1);
        chk("rst_bit_valid", bv_m, 1'b0);
        chk("rst_bit_out",   bo_m, 1'b0);
        check_outputs();
        #1 reset = 1'b0;
    endtask

    bit acc;
    bit drv_v;
    logic [W-1:0] drv_d;
    int density;

    initial begin
        model_reset();
        // Asynchronous reset with the clock stopped.
        #3 reset = 1'b1;
        #1;
        chk("rst0_din_ready",   rdy_m, 1'b1);
        chk("rst0_bit_valid",   bv_m,  1'b0);
        chk("rst0_bit_out",     bo_m,  1'b0);
        chk("rst0_frame_start", fs_m,  1'b0);
        chk("rst0_frame_end",   fe_m,  1'b0);
        chk("rst0_lsb_valid",   bv_l,  1'b0);
        clk_run = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_outputs();

        // Single word A5, MSB first.
        clear_stats();
        step(1'b1, 8'hA5, 1'b1, acc);
        step(1'b0, 8'h00, 1'b1, acc);
        for (int i = 0; i < W; i++) step(1'b0, 8'h00, 1'b1, acc);
        chk("a5_bits_msb", got_m, 32'h0000_00A5);
        chk("a5_bits_lsb", got_l, 32'h0000_00A5);
        chk("a5_frame_start_count", nfs, 1);
        chk("a5_frame_end_count", nfe, 1);
        chk("a5_valid_after", bv_m, 1'b0);

        // Back-to-back F0 then 0F.
        clear_stats();
        step(1'b1, 8'hF0, 1'b1, acc);
        step(1'b1, 8'hF0, 1'b1, acc);
        step(1'b1, 8'h0F, 1'b1, acc);
        for (int i = 0; i < 2 * W - 1; i++) step(1'b0, 8'h00, 1'b1, acc);
        chk("b2b_bits_msb", got_m, 32'h0000_F00F);
        chk("b2b_bits_lsb", got_l, 32'h0000_0FF0);
        chk("b2b_valid_cycles", nvalid, 2 * W);
        chk("b2b_bit_count", nbits, 2 * W);

        // bit_en every third cycle.
        clear_stats();
        step(1'b1, 8'hC3, 1'b0, acc);
        step(1'b0, 8'h00, 1'b0, acc);
        for (int i = 0; i < 3 * W; i++) step(1'b0, 8'h00, (i % 3) == 2, acc);
        chk("slow_bits_msb", got_m, 32'h0000_00C3);
        chk("slow_valid_cycles", nvalid, 3 * W);
        chk("slow_valid_after", bv_m, 1'b0);

        // Word 01 on both bit orders.
        clear_stats();
        step(1'b1, 8'h01, 1'b1, acc);
        for (int i = 0; i < W + 1; i++) step(1'b0, 8'h00, 1'b1, acc);
        chk("w01_bits_lsb", got_l, 32'h0000_0080);
        chk("w01_bits_msb", got_m, 32'h0000_0001);

        // Reset mid-word with a second word held, then a clean 81.
        step(1'b1, 8'hFF, 1'b1, acc);
        step(1'b0, 8'h00, 1'b1, acc);
        step(1'b1, 8'h5A, 1'b1, acc);
        step(1'b0, 8'h00, 1'b1, acc);
        step(1'b0, 8'h00, 1'b1, acc);
        chk("pre_rst_held", rdy_m, 1'b0);
        async_reset_pulse();
        clear_stats();
        step(1'b0, 8'h00, 1'b1, acc);
        chk("post_rst_idle", bv_m, 1'b0);
        step(1'b1, 8'h81, 1'b1, acc);
        step(1'b0, 8'h00, 1'b1, acc);
        chk("r81_frame_start", fs_m, 1'b1);
        for (int i = 0; i < W + 2; i++) step(1'b0, 8'h00, 1'b1, acc);
        chk("r81_bits_msb", got_m, 32'h0000_0081);
        chk("r81_bits_lsb", got_l, 32'h0000_0081);
        chk("r81_bit_count", nbits, W);

        // Randomized traffic with varying bit_en density and occasional resets.
        drv_v = 1'b0; drv_d = '0; acc = 1'b0; density = 100;
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) density = $urandom_range(20, 100);
            if (!drv_v || acc) begin
                drv_v = ($urandom_range(0, 3) != 0);
                drv_d = W'($urandom);
            end
            step(drv_v, drv_d, ($urandom_range(0, 99) < density), acc);
            if ($urandom_range(0, 499) == 0) begin
                async_reset_pulse();
                drv_v = 1'b0; acc = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
